// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU memory port and the responder
interface mem_responder_if #(parameter int ADDR_WIDTH = 32);
  logic req;
  logic we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ready;
  logic err;
  logic busy;
  modport master(output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave(input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory with configurable wait states, one-cycle ready pulse and address error flag
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int CW = (WAIT_CYCLES > 0 && $clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int LOAD = WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0;
  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = $clog2(DEPTH_WORDS);
  localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic we_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [31:0] wdata_l;
  logic [31:0] rdata_q;
  logic err_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [IW-1:0] idx;
  logic bad;
  logic commit;
  logic accept;
  // With zero wait states the commit edge is the accept edge, so the live inputs are used there
  always_comb begin
    accept = state == S_IDLE && bus.req;
    next = state == S_IDLE ? (bus.req ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) : S_IDLE) :
           state == S_WAIT ? (cnt == '0 ? S_RESP : S_WAIT) : S_IDLE;
    commit = next == S_RESP && state != S_RESP;
    acc_we = state == S_IDLE ? bus.we : we_l;
    acc_addr = state == S_IDLE ? bus.addr : addr_l;
    acc_wdata = state == S_IDLE ? bus.wdata : wdata_l;
    idx = acc_addr[ADDR_WIDTH-1:2];
    bad = (acc_addr[1:0] != 2'b00) || ({1'b0, idx} >= DEPTH_L);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      we_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        we_l <= bus.we;
        addr_l <= bus.addr;
        wdata_l <= bus.wdata;
        cnt <= CW'(LOAD);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        err_q <= bad;
        rdata_q <= bad ? 32'h0 : (acc_we ? rdata_q : mem[idx[MW-1:0]]);
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset && commit && acc_we && !bad) mem[idx[MW-1:0]] <= acc_wdata;
  assign bus.rdata = rdata_q;
  assign bus.err = err_q;
  assign bus.ready = state == S_RESP;
  assign bus.busy = state != S_IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of a 2-wait-state and a 0-wait-state responder sharing one stimulus
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_responder_if #(.ADDR_WIDTH(32)) b2 ();
  mem_responder_if #(.ADDR_WIDTH(32)) b0 ();
  assign b2.req = req;
  assign b2.we = we;
  assign b2.addr = addr;
  assign b2.wdata = wdata;
  assign b0.req = req;
  assign b0.we = we;
  assign b0.addr = addr;
  assign b0.wdata = wdata;
  mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
  mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask
  task automatic finish(input string tag, input logic w, input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    chk({tag, "_busy"}, 32'(b2.busy), 32'd1);
    while (!b2.ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 32'd2);
    chk({tag, "_err"}, 32'(b2.err), 32'(exp_e));
    if (!w || exp_e) chk({tag, "_rdata"}, b2.rdata, exp_d);
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, b2.ready, b2.busy}, 32'd0);
  endtask
  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
    issue(w, a, d);
    finish(tag, w, exp_d, exp_e);
  endtask
  initial begin
    int t_prev;
    int n;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];
    bb_addr[0] = 32'h10; bb_data[0] = 32'h12345678;
    bb_addr[1] = 32'h0;  bb_data[1] = 32'h11112222;
    bb_addr[2] = 32'hFC; bb_data[2] = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", {b2.rdata[3:0], b2.ready, b2.err, b2.busy}, 32'd0);
    chk("rst_rdata", b2.rdata, 32'd0);
    access("wr10", 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0);
    chk("wr10_keep", b2.rdata, 32'h0);
    access("rd10", 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
    access("rd13", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    access("wr11", 1'b1, 32'h11, 32'hDEADBEEF, 32'h0, 1'b1);
    access("rd10b", 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
    access("wr0", 1'b1, 32'h0, 32'h11112222, 32'h0, 1'b0);
    access("wrFC", 1'b1, 32'hFC, 32'h5A5A5A5A, 32'h0, 1'b0);
    access("wr100", 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    access("rd0", 1'b0, 32'h0, 32'h0, 32'h11112222, 1'b0);
    access("rdFC", 1'b0, 32'hFC, 32'h0, 32'h5A5A5A5A, 1'b0);
    access("rd_hi", 1'b0, 32'h4000_0000, 32'h0, 32'h0, 1'b1);
    // req held high: three reads, addr advanced at each ready
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = bb_addr[0];
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      n++;
      while (!b2.ready && n < 12) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) chk("bb_gap", n + t_prev, 32'd4);
      chk("bb_err", 32'(b2.err), 32'd0);
      chk("bb_rdata", b2.rdata, bb_data[i]);
      t_prev = 0;
      if (i < 2) addr = bb_addr[i + 1];
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    // zero wait states: ready right after accept, every other cycle
    req = 1'b1; addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("w0_ready", 32'(b0.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("w0_rdata", b0.rdata, 32'h12345678);
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    access("wr20", 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, b2.busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_rdy", {31'd0, b2.ready}, 32'd0);
      @(negedge clk);
    end
    access("rd20", 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);
    access("wrC", 1'b1, 32'hC, 32'h0C0C0C0C, 32'h0, 1'b0);
    issue(1'b1, 32'h8, 32'hCAFEF00D);
    we = 1'b1; addr = 32'hC; wdata = 32'h0;
    finish("chg", 1'b1, 32'h0, 1'b0);
    we = 1'b0; addr = '0;
    access("rd8", 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);
    access("rdC", 1'b0, 32'hC, 32'h0, 32'h0C0C0C0C, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
